// File: rtl/elbeth_pipeline_ctrl.sv
// Hazard/stall controller for the ELBETH 5-stage pipeline: derives per-register
// hold/bubble strobes, a data-memory timeout trap and a saturating stall counter.
module elbeth_pipeline_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int DMEM_TIMEOUT = 255,
  parameter int FLUSH_EXTRA  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] exs_rd_addr,
  input  logic                  exs_ctrl_reg_w,
  input  logic                  exs_ctrl_mem_en,
  input  logic                  exs_ctrl_mem_rw,
  input  logic                  exs_branch_taken,
  input  logic                  mem_ctrl_mem_en,
  input  logic                  dmem_ready,
  input  logic                  imem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_exs_stall,
  output logic                  id_exs_flush,
  output logic                  exs_mem_stall,
  output logic                  mem_wb_flush,
  output logic                  dmem_trap,
  output logic [31:0]           stall_count
);

  typedef enum logic [1:0] {RUN, DWAIT, FLUSH, TRAP} state_t;

  state_t      r_state;
  logic [15:0] r_waitCnt;
  logic [2:0]  r_flushCnt;
  logic        r_trap;
  logic [31:0] r_stallCount;

  state_t      w_nextState;
  logic [15:0] w_nextWaitCnt;
  logic [2:0]  w_nextFlushCnt;
  logic [16:0] w_waitInc;
  logic        w_loadUse;
  logic        w_dwait;
  logic        w_pcStall;
  logic        w_ifIdStall;
  logic        w_ifIdFlush;
  logic        w_idExsStall;
  logic        w_idExsFlush;
  logic        w_exsMemStall;
  logic        w_memWbFlush;

  assign w_loadUse = exs_ctrl_mem_en & ~exs_ctrl_mem_rw & exs_ctrl_reg_w &
                     (exs_rd_addr != '0) &
                     ((id_rs1_used & (id_rs1_addr == exs_rd_addr)) |
                      (id_rs2_used & (id_rs2_addr == exs_rd_addr)));
  assign w_dwait   = mem_ctrl_mem_en & ~dmem_ready;
  assign w_waitInc = {1'b0, r_waitCnt} + 17'd1;

  always_comb begin
    w_nextState    = r_state;
    w_nextWaitCnt  = r_waitCnt;
    w_nextFlushCnt = r_flushCnt;
    w_pcStall      = 1'b0;
    w_ifIdStall    = 1'b0;
    w_ifIdFlush    = 1'b0;
    w_idExsStall   = 1'b0;
    w_idExsFlush   = 1'b0;
    w_exsMemStall  = 1'b0;
    w_memWbFlush   = 1'b0;
    case (r_state)
      RUN, FLUSH: begin
        if (w_dwait) begin
          // The pending flush count survives the wait and is resumed afterwards.
          {w_pcStall, w_ifIdStall, w_idExsStall, w_exsMemStall, w_memWbFlush} = 5'b11111;
          w_nextWaitCnt = 16'd1;
          w_nextState   = (DMEM_TIMEOUT <= 1) ? TRAP : DWAIT;
        end else if (exs_branch_taken) begin
          w_ifIdFlush  = 1'b1;
          w_idExsFlush = 1'b1;
          if (FLUSH_EXTRA > 0) begin
            w_nextState    = FLUSH;
            w_nextFlushCnt = 3'(FLUSH_EXTRA);
          end else begin
            w_nextState    = RUN;
            w_nextFlushCnt = 3'd0;
          end
        end else begin
          if (r_state == FLUSH) begin
            w_ifIdFlush = 1'b1;
            if (r_flushCnt <= 3'd1) begin
              w_nextFlushCnt = 3'd0;
              w_nextState    = RUN;
            end else begin
              w_nextFlushCnt = r_flushCnt - 3'd1;
            end
          end
          // While IF/ID is being flushed the flush wins over holding it.
          if (w_loadUse) begin
            w_pcStall    = 1'b1;
            w_ifIdStall  = (r_state == RUN);
            w_idExsFlush = 1'b1;
          end else if (!imem_ready) begin
            w_pcStall   = 1'b1;
            w_ifIdFlush = 1'b1;
          end
        end
      end
      DWAIT: begin
        if (dmem_ready) begin
          w_nextWaitCnt = 16'd0;
          w_nextState   = (r_flushCnt != 3'd0) ? FLUSH : RUN;
        end else begin
          {w_pcStall, w_ifIdStall, w_idExsStall, w_exsMemStall, w_memWbFlush} = 5'b11111;
          w_nextWaitCnt = w_waitInc[15:0];
          if (w_waitInc >= 17'(DMEM_TIMEOUT)) w_nextState = TRAP;
        end
      end
      TRAP: begin
        {w_pcStall, w_ifIdStall, w_idExsStall, w_exsMemStall, w_memWbFlush} = 5'b11111;
      end
      default: w_nextState = RUN;
    endcase
  end

  assign pc_stall      = rst & w_pcStall;
  assign if_id_stall   = rst & w_ifIdStall;
  assign if_id_flush   = rst & w_ifIdFlush;
  assign id_exs_stall  = rst & w_idExsStall;
  assign id_exs_flush  = rst & w_idExsFlush;
  assign exs_mem_stall = rst & w_exsMemStall;
  assign mem_wb_flush  = rst & w_memWbFlush;
  assign dmem_trap     = r_trap;
  assign stall_count   = r_stallCount;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= RUN;
      r_waitCnt    <= 16'd0;
      r_flushCnt   <= 3'd0;
      r_trap       <= 1'b0;
      r_stallCount <= 32'd0;
    end else begin
      r_state    <= w_nextState;
      r_waitCnt  <= w_nextWaitCnt;
      r_flushCnt <= w_nextFlushCnt;
      if (w_nextState == TRAP) r_trap <= 1'b1;
      if (pc_stall && (r_stallCount != 32'hFFFF_FFFF)) r_stallCount <= r_stallCount + 32'd1;
    end
  end

endmodule
